// File: rtl/pipe_out_block_buffer.sv
// Block-aligned elastic FIFO in front of the block-throttled pipe-out endpoint.
// Optional statistics outputs are enabled by defining PIPE_OUT_BUF_STATS_EN.
module pipe_out_block_buffer #(
    parameter int DEPTH_LOG2  = 10,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  src_valid,
    input  logic [31:0]           src_data,
    output logic                  src_ready,
    input  logic                  pipe_out_read,
    output logic [31:0]           pipe_out_data,
    output logic                  pipe_out_ready,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic [15:0]           underrun_count
`ifdef PIPE_OUT_BUF_STATS_EN
    ,
    output logic [DEPTH_LOG2:0]   high_water,
    output logic [31:0]           blocks_done
`endif
);

    localparam int LW = DEPTH_LOG2 + 1;
    localparam int RW = $clog2(BLOCK_WORDS);
    localparam logic [LW-1:0] L_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [LW-1:0] L_BLOCK = LW'(BLOCK_WORDS);

    typedef enum logic {S_IDLE, S_BLOCK} state_t;

    logic [31:0]           r_mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic [31:0]           r_data;
    logic                  r_ready;
    logic [15:0]           r_underrun;
    state_t                r_state;
    logic [RW-1:0]         r_rem;

    state_t                w_state_next;
    logic [RW-1:0]         w_rem_next;
    logic                  w_block_end;
    logic                  w_wr;
    logic                  w_rd_ok;
    logic                  w_underrun;
    logic [LW-1:0]         w_level_next;
    logic [LW-1:0]         w_committed;
    logic                  w_ready_next;

    assign src_ready      = !reset && (r_level < L_FULL);
    assign w_wr           = src_valid && src_ready;
    assign w_rd_ok        = pipe_out_read && (r_level != '0);
    assign w_underrun     = pipe_out_read && (r_level == '0);
    assign w_level_next   = r_level + LW'(w_wr) - LW'(w_rd_ok);

    // A committed block is always fully buffered, so reads in BLOCK never underrun.
    always_comb begin
        w_state_next = r_state;
        w_rem_next   = r_rem;
        w_block_end  = 1'b0;
        if (pipe_out_read) begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_ready) begin
                        w_state_next = S_BLOCK;
                        w_rem_next   = RW'(BLOCK_WORDS - 1);
                    end
                end
                S_BLOCK: begin
                    if (r_rem == RW'(1)) begin
                        w_state_next = S_IDLE;
                        w_rem_next   = '0;
                        w_block_end  = 1'b1;
                    end else begin
                        w_rem_next = r_rem - RW'(1);
                    end
                end
            endcase
        end
    end

    assign w_committed  = (w_state_next == S_BLOCK) ? LW'(w_rem_next) : '0;
    assign w_ready_next = (w_level_next - w_committed) >= L_BLOCK;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= src_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_data     <= '0;
            r_ready    <= 1'b0;
            r_underrun <= '0;
            r_state    <= S_IDLE;
            r_rem      <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_data   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_underrun && (r_underrun != 16'hFFFF)) begin
                r_underrun <= r_underrun + 16'd1;
            end
            r_level <= w_level_next;
            r_ready <= w_ready_next;
            r_state <= w_state_next;
            r_rem   <= w_rem_next;
        end
    end

`ifdef PIPE_OUT_BUF_STATS_EN
    logic [LW-1:0] r_high;
    logic [31:0]   r_blocks;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_high   <= '0;
            r_blocks <= '0;
        end else begin
            if (w_level_next > r_high) begin
                r_high <= w_level_next;
            end
            if (w_block_end) begin
                r_blocks <= r_blocks + 32'd1;
            end
        end
    end

    assign high_water  = r_high;
    assign blocks_done = r_blocks;
`endif

    assign pipe_out_data  = r_data;
    assign pipe_out_ready = r_ready;
    assign fill_level     = r_level;
    assign underrun_count = r_underrun;

endmodule

// File: tb/tb_pipe_out_block_buffer.sv
// Self-checking bench for pipe_out_block_buffer against a queue-based model.
// Statistics outputs are checked when PIPE_OUT_BUF_STATS_EN is defined.
module tb_pipe_out_block_buffer;

    localparam int DL    = 10;
    localparam int DEPTH = 1 << DL;
    localparam int BW    = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          src_valid = 1'b0;
    logic [31:0]   src_data = '0;
    logic          src_ready;
    logic          pipe_out_read = 1'b0;
    logic [31:0]   pipe_out_data;
    logic          pipe_out_ready;
    logic [DL:0]   fill_level;
    logic [15:0]   underrun_count;
`ifdef PIPE_OUT_BUF_STATS_EN
    logic [DL:0]   high_water;
    logic [31:0]   blocks_done;
`endif

    pipe_out_block_buffer #(.DEPTH_LOG2(DL), .BLOCK_WORDS(BW)) dut (
        .clk            (clk),
        .reset          (reset),
        .src_valid      (src_valid),
        .src_data       (src_data),
        .src_ready      (src_ready),
        .pipe_out_read  (pipe_out_read),
        .pipe_out_data  (pipe_out_data),
        .pipe_out_ready (pipe_out_ready),
        .fill_level     (fill_level),
        .underrun_count (underrun_count)
`ifdef PIPE_OUT_BUF_STATS_EN
        ,
        .high_water     (high_water),
        .blocks_done    (blocks_done)
`endif
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model: word queue plus count of words still owed to the open block.
    int unsigned q[$];
    int unsigned m_under  = 0;
    int          m_rem    = 0;
    bit          m_ready  = 1'b0;
    logic [31:0] m_data   = '0;
    int          m_high   = 0;
    int unsigned m_blocks = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input logic [31:0] d,
                        input bit rd, input bit rst);
        bit acc;
        @(negedge clk);
        src_valid     = v;
        src_data      = d;
        pipe_out_read = rd;
        reset         = rst;
        acc = v && !rst && (q.size() < DEPTH);
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_under  = 0;
            m_rem    = 0;
            m_ready  = 1'b0;
            m_data   = '0;
            m_high   = 0;
            m_blocks = 0;
        end else begin
            if (rd) begin
                if (q.size() > 0) m_data = q.pop_front();
                else if (m_under < 65535) m_under++;
                if (m_rem > 0) begin
                    m_rem--;
                    if (m_rem == 0) m_blocks++;
                end else if (m_ready) begin
                    m_rem = BW - 1;
                end
            end
            if (acc) q.push_back(d);
            m_ready = (int'(q.size()) - m_rem) >= BW;
            if (q.size() > m_high) m_high = q.size();
        end
        chk("data", pipe_out_data, m_data);
        chk("ready", {31'd0, pipe_out_ready}, {31'd0, m_ready});
        chk("level", {21'd0, fill_level}, q.size());
        chk("underrun", {16'd0, underrun_count}, m_under);
        chk("src_ready", {31'd0, src_ready},
            {31'd0, (!rst && q.size() < DEPTH)});
`ifdef PIPE_OUT_BUF_STATS_EN
        chk("high_water", {21'd0, high_water}, m_high);
        chk("blocks_done", blocks_done, m_blocks);
`endif
    endtask

    initial begin
        int w;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_data", pipe_out_data, 32'd0);
        chk("rst_level", {21'd0, fill_level}, 32'd0);

        // 1: block threshold
        step(0, 0, 0, 0);
        chk("src_ready_after_rst", {31'd0, src_ready}, 32'd1);
        for (int i = 0; i < 255; i++) step(1, i, 0, 0);
        chk("t1_ready_255", {31'd0, pipe_out_ready}, 32'd0);
        chk("t1_level_255", {21'd0, fill_level}, 32'd255);
        step(1, 255, 0, 0);
        step(0, 0, 0, 0);
        chk("t1_ready_256", {31'd0, pipe_out_ready}, 32'd1);

        // 2: one block read back-to-back
        step(0, 0, 0, 1);
        for (int i = 0; i < 256; i++) step(1, 32'h1000 + i, 0, 0);
        step(0, 0, 1, 0);
        chk("t2_first", pipe_out_data, 32'h1000);
        chk("t2_ready_fall", {31'd0, pipe_out_ready}, 32'd0);
        for (int i = 1; i < 256; i++) step(0, 0, 1, 0);
        chk("t2_last", pipe_out_data, 32'h10FF);
        chk("t2_underrun", {16'd0, underrun_count}, 32'd0);

        // 3: second block buffered keeps ready high
        for (int i = 0; i < 512; i++) step(1, 32'h2000 + i, 0, 0);
        step(0, 0, 1, 0);
        chk("t3_ready_held", {31'd0, pipe_out_ready}, 32'd1);
        for (int i = 0; i < 511; i++) step(0, 0, 1, 0);
        chk("t3_level0", {21'd0, fill_level}, 32'd0);

        // 4: full FIFO, read with valid held, pointer wrap
        w = 0;
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 32'h3000 + w, 0, 0);
            w++;
        end
        chk("t4_full_src_ready", {31'd0, src_ready}, 32'd0);
        chk("t4_full_level", {21'd0, fill_level}, 32'd1024);
        step(1, 32'h3000 + w, 1, 0);
        step(1, 32'h3000 + w, 0, 0);
        chk("t4_refill_level", {21'd0, fill_level}, 32'd1024);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);
        chk("t4_last_word", pipe_out_data, 32'h3000 + w);

        // 5: underruns and saturation
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        chk("t5_under3", {16'd0, underrun_count}, 32'd3);
        for (int i = 0; i < 32'hFFFF + 5; i++) step(0, 0, 1, 0);
        chk("t5_sat", {16'd0, underrun_count}, 32'hFFFF);

        // 6: reset mid-block
        step(0, 0, 0, 1);
        for (int i = 0; i < 300; i++) step(1, 32'h4000 + i, 0, 0);
        for (int i = 0; i < 100; i++) step(0, 0, 1, 0);
`ifdef PIPE_OUT_BUF_STATS_EN
        chk("t6_high_pre", {21'd0, high_water}, 32'd300);
        chk("t6_blocks_pre", blocks_done, 32'd0);
`endif
        step(0, 0, 0, 1);
        chk("t6_rst_ready", {31'd0, pipe_out_ready}, 32'd0);
        chk("t6_rst_data", pipe_out_data, 32'd0);
        step(0, 0, 1, 0);
        chk("t6_underrun", {16'd0, underrun_count}, 32'd1);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 499) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
